// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the 8-bit FIFO onto a UART-style TX line.
// One pop per frame: start bit, data LSB first, optional parity, stop bit(s).
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
   } state_e;

   state_e            state_q, state_d;
   logic [BW-1:0]     baud_q, baud_d;
   logic [CW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              rd_q, rd_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              bit_end;
   logic              go;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      bit_end = (baud_q == BAUD_MAX);
      go      = en && !fifo_empty;

      if (state_q inside {START, DATA, PARITY, STOP}) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (go) state_d = FETCH;
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            shift_d = fifo_data;
            par_d   = (^fifo_data) ^ PARITY_ODD;
            baud_d  = '0;
            bit_d   = '0;
            state_d = START;
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 1'b1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = PARITY_EN ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) begin
               bit_d = bit_q + 1'b1;
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  state_d = go ? FETCH : IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so decode them from the upcoming state.
      rd_d   = (state_d == FETCH);
      busy_d = (state_d != IDLE);
      done_d = (state_d == STOP) && (baud_d == BAUD_MAX) &&
               (bit_d == STOP_LAST);
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
   end

   assign fifo_rd    = rd_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three drain stages with different framing, fed by FIFO
// models; a negedge monitor decodes each TX line against a frame model.
module tb_fifo_uart_tx;

   localparam int NCH = 3;
   localparam int CPB [NCH] = '{4, 4, 2};
   localparam int PE  [NCH] = '{0, 1, 1};
   localparam int PO  [NCH] = '{0, 0, 1};
   localparam int SB  [NCH] = '{1, 1, 2};
   localparam int DEPTH = 256;

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] en;
   logic [NCH-1:0] fifo_empty;
   logic [NCH-1:0] fifo_rd;
   logic [NCH-1:0] tx;
   logic [NCH-1:0] busy;
   logic [NCH-1:0] done;
   logic [7:0]     fdat [NCH] = '{default: 8'h00};

   logic [7:0] mem [NCH][DEPTH];
   int wr_n  [NCH] = '{default: 0};
   int rd_n  [NCH] = '{default: 0};
   int chk_n [NCH] = '{default: 0};

   int errors = 0;
   int checks = 0;
   int timeouts = 0;

   logic [NCH-1:0] a_tx, a_busy, a_rd, a_done;
   int  async_seq = 0, async_seen = 0;
   int  g_pend = 0, g_want = 0, gate_seq = 0, gate_seen = 0;
   logic g_busy;
   int  end_seq = 0;
   bit  mon_done = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign fifo_empty[g] = (rd_n[g] == wr_n[g]);
      fifo_uart_tx #(
         .CLKS_PER_BIT(CPB[g]),
         .DATA_W      (8),
         .PARITY_EN   (PE[g] != 0),
         .PARITY_ODD  (PO[g] != 0),
         .STOP_BITS   (SB[g])
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .en        (en[g]),
         .fifo_empty(fifo_empty[g]),
         .fifo_data (fdat[g]),
         .fifo_rd   (fifo_rd[g]),
         .tx        (tx[g]),
         .busy      (busy[g]),
         .frame_done(done[g])
      );
   end

   // FIFO read port: data appears the cycle after the pop strobe.
   always @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (fifo_rd[c] && rd_n[c] < wr_n[c]) begin
            fdat[c] <= mem[c][rd_n[c]];
            rd_n[c] <= rd_n[c] + 1;
         end
      end
   end

   function automatic int nslots(input int c);
      return 1 + 8 + PE[c] + SB[c];
   endfunction

   function automatic logic [15:0] frame_bits(input int c,
                                              input logic [7:0] b);
      logic [15:0] w;
      w = '0;
      for (int i = 0; i < nslots(c); i++) begin
         if (i == 0)                       w[i] = 1'b0;
         else if (i <= 8)                  w[i] = b[i-1];
         else if (PE[c] != 0 && i == 9)    w[i] = (^b) ^ (PO[c] != 0);
         else                              w[i] = 1'b1;
      end
      return w;
   endfunction

   int          k      [NCH] = '{default: -1};
   int          gap    [NCH] = '{default: 0};
   bit          b2b    [NCH] = '{default: 1'b0};
   bit          idlechk[NCH] = '{default: 1'b0};
   bit          prevok [NCH] = '{default: 1'b0};
   bit          prevrd [NCH] = '{default: 1'b0};
   logic [15:0] got    [NCH];
   bit          glitch [NCH];
   bit          bzbad  [NCH];
   int          dcnt   [NCH];
   int          dk     [NCH];

   always @(negedge clk) begin
      if (async_seq != async_seen) begin
         async_seen = async_seq;
         checks += 4;
         if (a_tx != '1) begin
            errors++;
            $display("FAIL reset tx: got %b want 111", a_tx);
         end
         if (a_busy != '0) begin
            errors++;
            $display("FAIL reset busy: got %b want 000", a_busy);
         end
         if (a_rd != '0) begin
            errors++;
            $display("FAIL reset fifo_rd: got %b want 000", a_rd);
         end
         if (a_done != '0) begin
            errors++;
            $display("FAIL reset frame_done: got %b want 000", a_done);
         end
      end
      if (gate_seq != gate_seen) begin
         gate_seen = gate_seq;
         checks += 2;
         if (g_pend != g_want) begin
            errors++;
            $display("FAIL gate queued: got %0d want %0d", g_pend, g_want);
         end
         if (g_busy !== 1'b0) begin
            errors++;
            $display("FAIL gate busy: got %b want 0", g_busy);
         end
      end

      for (int c = 0; c < NCH; c++) begin
         if (rst) begin
            // The in-flight byte is lost; resume after the last popped one.
            k[c] = -1;
            b2b[c] = 1'b0;
            idlechk[c] = 1'b0;
            prevok[c] = 1'b0;
            prevrd[c] = 1'b0;
            chk_n[c] = rd_n[c];
         end else begin
            if (fifo_rd[c]) begin
               checks++;
               if (!prevok[c] || prevrd[c] || fifo_empty[c]) begin
                  errors++;
                  $display("FAIL ch%0d pop: prev_ok=%b prev_rd=%b empty=%b want 1/0/0",
                           c, prevok[c], prevrd[c], fifo_empty[c]);
               end
            end
            prevok[c] = en[c] && !fifo_empty[c];
            prevrd[c] = fifo_rd[c];

            if (k[c] < 0) begin
               if (idlechk[c]) begin
                  idlechk[c] = 1'b0;
                  checks++;
                  if (busy[c]) begin
                     errors++;
                     $display("FAIL ch%0d idle busy: got 1 want 0", c);
                  end
               end
               if (done[c]) begin
                  checks++;
                  errors++;
                  $display("FAIL ch%0d stray frame_done: got 1 want 0", c);
               end
               if (tx[c] == 1'b0) begin
                  if (b2b[c]) begin
                     checks++;
                     if (gap[c] != 2) begin
                        errors++;
                        $display("FAIL ch%0d gap: got %0d want 2", c, gap[c]);
                     end
                  end
                  b2b[c] = 1'b0;
                  k[c] = 0;
                  got[c] = '0;
                  glitch[c] = 1'b0;
                  bzbad[c] = 1'b0;
                  dcnt[c] = 0;
                  dk[c] = -1;
               end else if (b2b[c]) begin
                  gap[c]++;
                  if (gap[c] > 2) begin
                     checks++;
                     errors++;
                     $display("FAIL ch%0d gap: got >2 want 2", c);
                     b2b[c] = 1'b0;
                  end
               end
            end

            if (k[c] >= 0) begin
               if (k[c] % CPB[c] == 0) got[c][k[c] / CPB[c]] = tx[c];
               else if (tx[c] != got[c][k[c] / CPB[c]]) glitch[c] = 1'b1;
               if (done[c]) begin
                  dcnt[c]++;
                  dk[c] = k[c];
               end
               if (!busy[c]) bzbad[c] = 1'b1;
               if (k[c] == nslots(c) * CPB[c] - 1) begin
                  checks += 4;
                  if (chk_n[c] >= wr_n[c]) begin
                     errors++;
                     $display("FAIL ch%0d frame: got %h with nothing queued", c, got[c]);
                  end else if (got[c] != frame_bits(c, mem[c][chk_n[c]])) begin
                     errors++;
                     $display("FAIL ch%0d frame byte %h: got %h want %h", c,
                              mem[c][chk_n[c]], got[c],
                              frame_bits(c, mem[c][chk_n[c]]));
                  end
                  if (glitch[c]) begin
                     errors++;
                     $display("FAIL ch%0d bit width: got glitch want %0d clk/bit",
                              c, CPB[c]);
                  end
                  if (dcnt[c] != 1 || dk[c] != k[c]) begin
                     errors++;
                     $display("FAIL ch%0d frame_done: got %0d at %0d want 1 at %0d",
                              c, dcnt[c], dk[c], k[c]);
                  end
                  if (bzbad[c]) begin
                     errors++;
                     $display("FAIL ch%0d busy in frame: got 0 want 1", c);
                  end
                  chk_n[c]++;
                  b2b[c] = en[c] && !fifo_empty[c];
                  idlechk[c] = !b2b[c];
                  gap[c] = 0;
                  k[c] = -1;
               end else begin
                  k[c]++;
               end
            end
         end
      end

      if (end_seq != 0 && !mon_done) begin
         checks++;
         if (timeouts != 0) begin
            errors++;
            $display("FAIL drain timeout: got %0d want 0", timeouts);
         end
         for (int c = 0; c < NCH; c++) begin
            checks += 2;
            if (rd_n[c] != wr_n[c]) begin
               errors++;
               $display("FAIL ch%0d pops: got %0d want %0d", c, rd_n[c], wr_n[c]);
            end
            if (chk_n[c] != wr_n[c]) begin
               errors++;
               $display("FAIL ch%0d frames: got %0d want %0d", c, chk_n[c], wr_n[c]);
            end
         end
         mon_done = 1'b1;
      end
   end

   task automatic push(input int c, input logic [7:0] b);
      mem[c][wr_n[c]] = b;
      wr_n[c] = wr_n[c] + 1;
   endtask

   function automatic bit pending();
      for (int c = 0; c < NCH; c++)
         if (en[c] && rd_n[c] != wr_n[c]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain(input int limit);
      int n;
      n = 0;
      while (n < limit && (busy != '0 || pending())) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= limit) timeouts++;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      en  = '0;
      #3;
      a_tx = tx; a_busy = busy; a_rd = fifo_rd; a_done = done;
      async_seq++;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      en = '1;
      push(0, 8'hA5);
      push(1, 8'hA5);
      push(2, 8'h80);
      drain(400);

      push(1, 8'h01);
      push(2, 8'h01);
      drain(400);

      push(0, 8'h00);
      push(0, 8'hFF);
      push(0, 8'h3C);
      drain(600);

      push(0, 8'h11);
      push(0, 8'h22);
      push(0, 8'h33);
      repeat (10) @(posedge clk);
      #1 en[0] = 1'b0;
      drain(400);
      repeat (20) @(posedge clk);
      #1;
      g_pend = wr_n[0] - rd_n[0];
      g_want = 2;
      g_busy = busy[0];
      gate_seq++;
      en[0] = 1'b1;
      drain(600);

      for (int it = 0; it < 30; it++) begin
         int c;
         c = $urandom_range(0, NCH - 1);
         for (int j = 0; j < int'($urandom_range(1, 3)); j++)
            push(c, 8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1 en[c] = 1'b0;
            repeat ($urandom_range(0, 60)) @(posedge clk);
            #1 en[c] = 1'b1;
         end
         repeat ($urandom_range(0, 50)) @(posedge clk);
         #1;
      end
      en = '1;
      drain(4000);

      push(0, 8'h5A);
      push(0, 8'hC3);
      repeat (14) @(posedge clk);
      #2 rst = 1'b1;
      en[0] = 1'b0;
      #1;
      a_tx = tx; a_busy = busy; a_rd = fifo_rd; a_done = done;
      async_seq++;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1 en[0] = 1'b1;
      drain(400);

      end_seq = 1;
      for (int i = 0; i < 100 && !mon_done; i++) @(negedge clk);
      #1;
      if (!mon_done) begin
         $display("FAIL monitor: end checks not reached");
         $fatal(1, "monitor stalled");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
